bt_calc_host: RTL and testbench

Host-side sequencer for the balanced-ternary calculator core. It accepts two signed binary operands over a valid/ready handshake, encodes them as 2-bit trits, drives the calculator's 8-bit input bus, and waits a settle period. It then captures and stability-checks the 8-bit trit result, decodes it to signed binary, and returns it over a second valid/ready handshake. The block sits between on-chip/scan-chain control logic and the calculator, replacing hand-driven stimulus.

---
 rtl/bt_calc_pkg.sv | 39 +++
 rtl/bt_result_decoder.sv | 31 +++
 rtl/bt_calc_host.sv | 119 +++++++++++
 tb/tb_bt_calc_host.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bt_calc_pkg.sv
// Shared definitions for the balanced-ternary calculator host: trit codes,
// error codes, sequencer states and the operand encoder.
package bt_calc_pkg;

  localparam logic [1:0] TRIT_NEG  = 2'b01;
  localparam logic [1:0] TRIT_ZERO = 2'b11;
  localparam logic [1:0] TRIT_POS  = 2'b10;
  localparam logic [1:0] TRIT_ILL  = 2'b00;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_RANGE    = 2'd1;
  localparam logic [1:0] ERR_TRIT     = 2'd2;
  localparam logic [1:0] ERR_UNSTABLE = 2'd3;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, RESP} state_t;

  // Two's complement patterns 5..7 and -8..-5 occupy codes 4'h5..4'hB.
  function automatic logic in_range(input logic [3:0] v);
    return !((v >= 4'd5) && (v <= 4'd11));
  endfunction

  function automatic logic [3:0] enc_operand(input logic [3:0] v);
    logic [3:0] t;
    case (v)
      4'hC:    t = {TRIT_NEG,  TRIT_NEG};
      4'hD:    t = {TRIT_NEG,  TRIT_ZERO};
      4'hE:    t = {TRIT_NEG,  TRIT_POS};
      4'hF:    t = {TRIT_ZERO, TRIT_NEG};
      4'h0:    t = {TRIT_ZERO, TRIT_ZERO};
      4'h1:    t = {TRIT_ZERO, TRIT_POS};
      4'h2:    t = {TRIT_POS,  TRIT_NEG};
      4'h3:    t = {TRIT_POS,  TRIT_ZERO};
      4'h4:    t = {TRIT_POS,  TRIT_POS};
      default: t = {TRIT_ZERO, TRIT_ZERO};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/bt_result_decoder.sv
// Combinational decoder: four 2-bit trits (r3..r0) to a signed 7-bit value,
// flagging any illegal 00 code.
module bt_result_decoder
  import bt_calc_pkg::*;
(
  input  logic        [7:0] trits,
  output logic signed [6:0] value,
  output logic              illegal
);

  function automatic logic signed [6:0] weigh(input logic [1:0] code,
                                               input logic signed [6:0] w);
    logic signed [6:0] r;
    case (code)
      TRIT_POS: r = w;
      TRIT_NEG: r = -w;
      default:  r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    illegal = (trits[7:6] == TRIT_ILL) || (trits[5:4] == TRIT_ILL) ||
              (trits[3:2] == TRIT_ILL) || (trits[1:0] == TRIT_ILL);
    value   = '0;
    if (!illegal)
      value = weigh(trits[7:6], 7'sd27) + weigh(trits[5:4], 7'sd9) +
              weigh(trits[3:2], 7'sd3)  + weigh(trits[1:0], 7'sd1);
  end

endmodule

// File: rtl/bt_calc_host.sv
// Host sequencer for the balanced-ternary calculator core: encodes operands,
// waits for the core to settle, double-samples the result and returns it.
module bt_calc_host
  import bt_calc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_RETRY     = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  output logic [7:0] calc_in,
  input  logic [7:0] calc_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [6:0] res_value,
  output logic [1:0] res_err
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RETRY_W-1:0] retry, retry_n;
  logic [7:0]         calc_in_n;
  logic [7:0]         s0, s0_n;
  logic [6:0]         value_n;
  logic [1:0]         err_n;
  logic signed [6:0]  dec_value;
  logic               dec_illegal;

  bt_result_decoder u_dec (
    .trits   (s0),
    .value   (dec_value),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      retry     <= '0;
      calc_in   <= 8'hFF;
      s0        <= '0;
      res_value <= '0;
      res_err   <= ERR_OK;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry     <= retry_n;
      calc_in   <= calc_in_n;
      s0        <= s0_n;
      res_value <= value_n;
      res_err   <= err_n;
    end
  end

  // The second sample is the live calc_out; s0 holds the first.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    retry_n   = retry;
    calc_in_n = calc_in;
    s0_n      = s0;
    value_n   = res_value;
    err_n     = res_err;
    case (state)
      IDLE: begin
        if (op_valid) begin
          if (!in_range(op_a) || !in_range(op_b)) begin
            state_n = RESP;
            err_n   = ERR_RANGE;
            value_n = '0;
          end else begin
            calc_in_n = {enc_operand(op_a), enc_operand(op_b)};
            cnt_n     = CNT_W'(SETTLE_CYCLES - 1);
            retry_n   = '0;
            state_n   = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          s0_n    = calc_out;
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SAMPLE: begin
        if (s0 == calc_out) begin
          state_n = RESP;
          value_n = dec_illegal ? 7'd0 : dec_value;
          err_n   = dec_illegal ? ERR_TRIT : ERR_OK;
        end else if (retry < RETRY_W'(MAX_RETRY)) begin
          retry_n = retry + 1'b1;
          cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
          state_n = SETTLE;
        end else begin
          state_n = RESP;
          value_n = '0;
          err_n   = ERR_UNSTABLE;
        end
      end
      RESP: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign op_ready  = (state == IDLE) && !rst;
  assign res_valid = (state == RESP);

endmodule

// File: tb/tb_bt_calc_host.sv
// Self-checking bench for bt_calc_host: directed and randomized operations
// checked against an arithmetic model of trit encoding and decoding.
module tb_bt_calc_host;

  localparam int SETTLE_CYCLES = 4;
  localparam int MAX_RETRY     = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_a, op_b;
  logic [7:0] calc_in;
  logic [7:0] calc_out;
  logic       res_valid;
  logic       res_ready;
  logic [6:0] res_value;
  logic [1:0] res_err;

  logic [7:0] core_val = 8'hFF;
  logic [7:0] tog_val  = 8'h96;
  logic       toggle   = 1'b0;
  logic [7:0] last_calc;

  int checks = 0;
  int errors = 0;

  bt_calc_host #(.SETTLE_CYCLES(SETTLE_CYCLES), .MAX_RETRY(MAX_RETRY), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .calc_in   (calc_in),
    .calc_out  (calc_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_value (res_value),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  // Core stand-in: either a fixed result or a never-settling 0x96/0xEB toggle.
  always @(posedge clk) tog_val <= (tog_val == 8'h96) ? 8'hEB : 8'h96;
  assign calc_out = toggle ? tog_val : core_val;

  function automatic logic [1:0] trit_code(input int t);
    if (t < 0) return 2'b01;
    if (t == 0) return 2'b11;
    return 2'b10;
  endfunction

  function automatic logic [3:0] enc_model(input int v);
    int t0, t1;
    t0 = (((v % 3) + 4) % 3) - 1;
    t1 = (v - t0) / 3;
    return {trit_code(t1), trit_code(t0)};
  endfunction

  function automatic bit trits_legal(input logic [7:0] c);
    for (int i = 0; i < 4; i++)
      if (c[2*i +: 2] == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int trits_value(input logic [7:0] c);
    int sum, w;
    sum = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      if (c[2*i +: 2] == 2'b10) sum += w;
      else if (c[2*i +: 2] == 2'b01) sum -= w;
      w *= 3;
    end
    return sum;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int a, input int b, input logic [7:0] cout,
                                input bit tog, input int stall);
    logic [7:0] exp_calc;
    logic [6:0] exp_val;
    logic [1:0] exp_err;
    int         lat, k, v;
    bit         got;
    if (a < -4 || a > 4 || b < -4 || b > 4) begin
      exp_calc = last_calc;
      exp_val  = 7'd0;
      exp_err  = 2'd1;
      lat      = 1;
    end else begin
      exp_calc = {enc_model(a), enc_model(b)};
      if (tog) begin
        exp_val = 7'd0;
        exp_err = 2'd3;
        lat     = (SETTLE_CYCLES + 1) * (MAX_RETRY + 1) + 1;
      end else if (!trits_legal(cout)) begin
        exp_val = 7'd0;
        exp_err = 2'd2;
        lat     = SETTLE_CYCLES + 2;
      end else begin
        v       = trits_value(cout);
        exp_val = v[6:0];
        exp_err = 2'd0;
        lat     = SETTLE_CYCLES + 2;
      end
    end

    @(negedge clk);
    check_output("op_ready_idle", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op_a     = a[3:0];
    op_b     = b[3:0];
    core_val = cout;
    toggle   = tog;
    k   = 0;
    got = 1'b0;
    while (k < 100 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        op_valid = 1'b0;
        check_output("calc_in", 32'(calc_in), 32'(exp_calc));
      end
      if (res_valid) got = 1'b1;
    end
    check_output("latency", 32'(k), 32'(lat));
    check_output("res_value", 32'(res_value), 32'(exp_val));
    check_output("res_err", 32'(res_err), 32'(exp_err));

    op_valid = (stall > 0);
    op_a     = 4'd1;
    op_b     = 4'd1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_output("stall_valid", 32'(res_valid), 32'd1);
      check_output("stall_value", 32'(res_value), 32'(exp_val));
      check_output("stall_err", 32'(res_err), 32'(exp_err));
      check_output("stall_op_ready", 32'(op_ready), 32'd0);
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    toggle    = 1'b0;
    check_output("valid_drop", 32'(res_valid), 32'd0);
    check_output("op_ready_back", 32'(op_ready), 32'd1);
    check_output("calc_in_hold", 32'(calc_in), 32'(exp_calc));
    last_calc = exp_calc;
  endtask

  initial begin
    int a, b, r;
    logic [7:0] cout;
    rst       = 1'b1;
    op_valid  = 1'b0;
    op_a      = 4'd0;
    op_b      = 4'd0;
    res_ready = 1'b0;
    last_calc = 8'hFF;
    repeat (2) @(negedge clk);
    check_output("rst_op_ready", 32'(op_ready), 32'd0);
    check_output("rst_calc_in", 32'(calc_in), 32'hFF);
    check_output("rst_res_valid", 32'(res_valid), 32'd0);
    check_output("rst_res_value", 32'(res_value), 32'd0);
    check_output("rst_res_err", 32'(res_err), 32'd0);
    rst = 1'b0;

    $display("[TB] directed operations");
    apply_stimulus(-4, -4, 8'h96, 1'b0, 0);
    apply_stimulus(-3,  2, 8'hDB, 1'b0, 0);
    apply_stimulus(-1, -4, 8'hDA, 1'b0, 0);
    apply_stimulus( 4,  4, 8'hED, 1'b0, 0);
    apply_stimulus( 1,  0, 8'h3F, 1'b0, 0);
    apply_stimulus( 5,  0, 8'h96, 1'b0, 0);
    apply_stimulus( 0, -8, 8'h96, 1'b0, 0);
    apply_stimulus( 2, -2, 8'h96, 1'b1, 0);
    apply_stimulus( 3, -3, 8'h96, 1'b0, 10);

    $display("[TB] reset during settle");
    @(negedge clk);
    core_val = 8'h96;
    op_valid = 1'b1;
    op_a     = 4'd1;
    op_b     = 4'd1;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_calc_in", 32'(calc_in), 32'hFF);
    check_output("midrst_res_valid", 32'(res_valid), 32'd0);
    check_output("midrst_op_ready", 32'(op_ready), 32'd0);
    rst = 1'b0;
    last_calc = 8'hFF;
    @(negedge clk);
    check_output("postrst_op_ready", 32'(op_ready), 32'd1);
    check_output("postrst_res_valid", 32'(res_valid), 32'd0);
    apply_stimulus(-2, 3, 8'hEE, 1'b0, 0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 24; n++) begin
      a = int'($urandom_range(0, 8)) - 4;
      b = int'($urandom_range(0, 8)) - 4;
      if ($urandom_range(0, 7) == 0) begin
        r = int'($urandom_range(0, 6));
        a = (r < 3) ? 5 + r : -5 - (r - 3);
      end
      for (int i = 0; i < 4; i++) begin
        r = int'($urandom_range(0, 9));
        cout[2*i +: 2] = (r == 0) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b11 : 2'b10;
      end
      apply_stimulus(a, b, cout, 1'b0, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
